// File: rtl/ast_width_downsizer_pkg.sv
// Shared widths, derived ratios, typedefs and beat-count helper for the
// Avalon-ST wide-to-narrow width downsizer.
package ast_width_downsizer_pkg;

  localparam int DATA_IN_W   = 128;
  localparam int DATA_OUT_W  = 64;
  localparam int CHANNEL_W   = 10;
  localparam int EMPTY_IN_W  = ($clog2(DATA_IN_W / 8) > 1) ? $clog2(DATA_IN_W / 8) : 1;
  localparam int EMPTY_OUT_W = ($clog2(DATA_OUT_W / 8) > 1) ? $clog2(DATA_OUT_W / 8) : 1;

  localparam int RATIO = DATA_IN_W / DATA_OUT_W;
  localparam int OB    = DATA_OUT_W / 8;

  typedef logic [CHANNEL_W-1:0]   channel_t;
  typedef logic [EMPTY_IN_W-1:0]  empty_in_t;
  typedef logic [EMPTY_OUT_W-1:0] empty_out_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_SEND  = 1'b1
  } state_e;

  // Number of narrow beats needed to carry vb valid bytes, ob bytes per beat.
  function automatic int beat_count(input int vb, input int ob);
    return (vb + ob - 1) / ob;
  endfunction

endpackage

// File: rtl/ast_width_downsizer.sv
// Splits each wide Avalon-ST word into narrow beats; beat 0 is visible the cycle after accept.
// Holds outputs stable under backpressure; ready_o rises on the last beat handshake so words stream without bubbles.
module ast_width_downsizer #(
  parameter int DATA_IN_W   = ast_width_downsizer_pkg::DATA_IN_W,
  parameter int DATA_OUT_W  = ast_width_downsizer_pkg::DATA_OUT_W,
  parameter int CHANNEL_W   = ast_width_downsizer_pkg::CHANNEL_W,
  parameter int EMPTY_IN_W  = ast_width_downsizer_pkg::EMPTY_IN_W,
  parameter int EMPTY_OUT_W = ast_width_downsizer_pkg::EMPTY_OUT_W
) (
  input  logic                   clk_i,
  input  logic                   srst_n_i,
  input  logic [DATA_IN_W-1:0]   ast_data_i,
  input  logic                   ast_startofpacket_i,
  input  logic                   ast_endofpacket_i,
  input  logic                   ast_valid_i,
  input  logic [EMPTY_IN_W-1:0]  ast_empty_i,
  input  logic [CHANNEL_W-1:0]   ast_channel_i,
  output logic                   ast_ready_o,
  output logic [DATA_OUT_W-1:0]  ast_data_o,
  output logic                   ast_startofpacket_o,
  output logic                   ast_endofpacket_o,
  output logic                   ast_valid_o,
  output logic [EMPTY_OUT_W-1:0] ast_empty_o,
  output logic [CHANNEL_W-1:0]   ast_channel_o,
  input  logic                   ast_ready_i
);
  import ast_width_downsizer_pkg::*;

  localparam int RATIO_L = DATA_IN_W / DATA_OUT_W;
  localparam int OB_L    = DATA_OUT_W / 8;
  localparam int IB_L    = DATA_IN_W / 8;
  localparam int IDX_W   = (RATIO_L > 1) ? $clog2(RATIO_L) : 1;

  state_e                               r_state;
  state_e                               w_state_nxt;
  logic [RATIO_L-1:0][DATA_OUT_W-1:0]   r_data;
  logic                                 r_sop;
  logic                                 r_eop;
  logic [CHANNEL_W-1:0]                 r_channel;
  logic [EMPTY_OUT_W-1:0]               r_empty_last;
  logic [IDX_W-1:0]                     r_idx;
  logic [IDX_W-1:0]                     r_last_idx;

  logic w_last;
  logic w_accept;
  logic w_beat_hs;
  logic w_valid;
  int   w_vb;
  int   w_nb;

  assign w_last      = (r_idx == r_last_idx);
  assign ast_ready_o = srst_n_i && ((r_state == ST_EMPTY) || (w_last && ast_ready_i));
  assign w_accept    = ast_valid_i && ast_ready_o;
  assign w_beat_hs   = w_valid && ast_ready_i;

  // Empty only counts on the eop word; it decides how many beats to emit.
  always_comb begin
    w_vb = IB_L;
    if (ast_endofpacket_i) begin
      w_vb = IB_L - int'(ast_empty_i);
    end
    w_nb = beat_count(w_vb, OB_L);
  end

  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_valid     = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        w_valid = 1'b1;
        if (w_beat_hs && w_last && !w_accept) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      r_data       <= '0;
      r_sop        <= 1'b0;
      r_eop        <= 1'b0;
      r_channel    <= '0;
      r_empty_last <= '0;
      r_idx        <= '0;
      r_last_idx   <= '0;
    end else if (w_accept) begin
      r_data       <= ast_data_i;
      r_sop        <= ast_startofpacket_i;
      r_eop        <= ast_endofpacket_i;
      r_channel    <= ast_channel_i;
      r_empty_last <= EMPTY_OUT_W'(w_nb * OB_L - w_vb);
      r_idx        <= '0;
      r_last_idx   <= IDX_W'(w_nb - 1);
    end else if (w_beat_hs) begin
      r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
    end
  end

  assign ast_valid_o         = w_valid;
  assign ast_data_o          = r_data[r_idx];
  assign ast_startofpacket_o = w_valid && r_sop && (r_idx == '0);
  assign ast_endofpacket_o   = w_valid && r_eop && w_last;
  assign ast_empty_o         = ast_endofpacket_o ? r_empty_last : '0;
  assign ast_channel_o       = r_channel;

endmodule

// File: tb/tb_ast_width_downsizer.sv
// Directed and randomised-backpressure bench for the 128->64 Avalon-ST downsizer.
module tb_ast_width_downsizer;
  import ast_width_downsizer_pkg::*;

  logic                   clk_i;
  logic                   srst_n_i;
  logic [DATA_IN_W-1:0]   ast_data_i;
  logic                   ast_startofpacket_i;
  logic                   ast_endofpacket_i;
  logic                   ast_valid_i;
  empty_in_t              ast_empty_i;
  channel_t               ast_channel_i;
  logic                   ast_ready_o;
  logic [DATA_OUT_W-1:0]  ast_data_o;
  logic                   ast_startofpacket_o;
  logic                   ast_endofpacket_o;
  logic                   ast_valid_o;
  empty_out_t             ast_empty_o;
  channel_t               ast_channel_o;
  logic                   ast_ready_i;

  ast_width_downsizer dut (
    .clk_i               (clk_i),
    .srst_n_i            (srst_n_i),
    .ast_data_i          (ast_data_i),
    .ast_startofpacket_i (ast_startofpacket_i),
    .ast_endofpacket_i   (ast_endofpacket_i),
    .ast_valid_i         (ast_valid_i),
    .ast_empty_i         (ast_empty_i),
    .ast_channel_i       (ast_channel_i),
    .ast_ready_o         (ast_ready_o),
    .ast_data_o          (ast_data_o),
    .ast_startofpacket_o (ast_startofpacket_o),
    .ast_endofpacket_o   (ast_endofpacket_o),
    .ast_valid_o         (ast_valid_o),
    .ast_empty_o         (ast_empty_o),
    .ast_channel_o       (ast_channel_o),
    .ast_ready_i         (ast_ready_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [127:0] data;
    bit           sop;
    bit           eop;
    empty_in_t    empty;
    channel_t     ch;
    int           dly;
  } word_t;

  int            n_cmp = 0;
  int            n_fail = 0;
  logic [127:0]  d0, d1, d2;
  logic [127:0]  pw [3];
  word_t         words [$];
  logic [7:0]    tx_q [$];
  logic [7:0]    rx_q [$];
  channel_t      pkt_ch [$];
  word_t         wt;
  int            wi, dly, rx_pkts, nbytes, wd, k, nw, vb;
  bit            presenting, stalled, exp_sop;
  logic [127:0]  saved, cur;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit v, input logic [127:0] d, input bit s, input bit e,
                       input empty_in_t em, input channel_t ch);
    ast_valid_i         = v;
    ast_data_i          = d;
    ast_startofpacket_i = s;
    ast_endofpacket_i   = e;
    ast_empty_i         = em;
    ast_channel_i       = ch;
  endtask

  task automatic next();
    @(posedge clk_i);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk_i);
  endtask

  // Starts and ends just after a rising edge; nb and exp_empty are hand-computed by the caller.
  task automatic one_word(input string tag, input logic [127:0] d, input bit s, input bit e,
                          input empty_in_t em, input channel_t ch, input int nb,
                          input empty_out_t exp_empty);
    ast_ready_i = 1'b1;
    drive(1'b1, d, s, e, em, ch);
    at_neg();
    chk({tag, " rdy_idle"}, ast_ready_o, 1);
    next();
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
    for (int b = 0; b < nb; b++) begin
      at_neg();
      chk($sformatf("%s b%0d vld", tag, b), ast_valid_o, 1);
      chk($sformatf("%s b%0d dat", tag, b), ast_data_o, d[b*64 +: 64]);
      chk($sformatf("%s b%0d sop", tag, b), ast_startofpacket_o, s && (b == 0));
      chk($sformatf("%s b%0d eop", tag, b), ast_endofpacket_o, e && (b == nb - 1));
      chk($sformatf("%s b%0d emp", tag, b), ast_empty_o,
          (e && (b == nb - 1)) ? exp_empty : empty_out_t'(0));
      chk($sformatf("%s b%0d ch", tag, b), ast_channel_o, ch);
      chk($sformatf("%s b%0d rdy", tag, b), ast_ready_o, b == nb - 1);
      next();
    end
    at_neg();
    chk({tag, " idle_vld"}, ast_valid_o, 0);
    next();
  endtask

  initial begin
    srst_n_i    = 1'b0;
    ast_ready_i = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
    d0 = 128'h0F0E0D0C0B0A09080706050403020100;
    d1 = 128'hA5A4A3A2A1A09F9E9D9C9B9A99989796;
    d2 = 128'h112233445566778899AABBCCDDEEFF00;

    // Reset state
    repeat (3) @(posedge clk_i);
    #1;
    at_neg();
    chk("rst vld", ast_valid_o, 0);
    chk("rst rdy", ast_ready_o, 0);
    chk("rst sop", ast_startofpacket_o, 0);
    chk("rst eop", ast_endofpacket_o, 0);
    chk("rst dat", ast_data_o, 0);
    chk("rst emp", ast_empty_o, 0);
    chk("rst ch", ast_channel_o, 0);
    srst_n_i = 1'b1;
    #1;
    chk("rel rdy", ast_ready_o, 1);
    next();

    // Single words: full, partial eop, exact half, ignored empty on non-eop
    one_word("full", d0, 1'b1, 1'b1, 4'd0, 10'd5, 2, 3'd0);
    one_word("e9",   d0, 1'b1, 1'b1, 4'd9, 10'd3, 1, 3'd1);
    one_word("e8",   d0, 1'b1, 1'b1, 4'd8, 10'd3, 1, 3'd0);
    one_word("e3",   d0, 1'b1, 1'b1, 4'd3, 10'd3, 2, 3'd3);
    one_word("ign",  d1, 1'b1, 1'b0, 4'd9, 10'h3FF, 2, 3'd0);
    one_word("e15",  d2, 1'b0, 1'b1, 4'd15, 10'd1, 1, 3'd7);

    // Back-to-back 3-word packet: no gaps, ready pattern 1,0,1,0,1,0,1
    for (int i = 0; i < 3; i++)
      for (int b = 0; b < 16; b++)
        pw[i][b*8 +: 8] = 8'(16 * (i + 1) + b);
    ast_ready_i = 1'b1;
    wi = 0;
    for (int c = 0; c < 7; c++) begin
      if (wi < 3) drive(1'b1, pw[wi], wi == 0, wi == 2, '0, 10'h2A);
      else        drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
      at_neg();
      chk($sformatf("b2b c%0d rdy", c), ast_ready_o, (c % 2) == 0);
      if (c > 0) begin
        wd = (c - 1) / 2;
        k  = (c - 1) % 2;
        chk($sformatf("b2b c%0d vld", c), ast_valid_o, 1);
        chk($sformatf("b2b c%0d dat", c), ast_data_o, pw[wd][k*64 +: 64]);
        chk($sformatf("b2b c%0d sop", c), ast_startofpacket_o, (wd == 0) && (k == 0));
        chk($sformatf("b2b c%0d eop", c), ast_endofpacket_o, (wd == 2) && (k == 1));
        chk($sformatf("b2b c%0d ch", c), ast_channel_o, 10'h2A);
      end
      if ((c % 2) == 0 && wi < 3) wi++;
      next();
    end
    at_neg();
    chk("b2b idle", ast_valid_o, 0);
    next();

    // Reset while beat 0 of a 2-beat word is held
    ast_ready_i = 1'b0;
    drive(1'b1, d1, 1'b1, 1'b1, '0, 10'd7);
    at_neg();
    next();
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
    at_neg();
    chk("mid vld", ast_valid_o, 1);
    chk("mid dat", ast_data_o, d1[63:0]);
    next();
    srst_n_i = 1'b0;
    at_neg();
    chk("mid rst rdy", ast_ready_o, 0);
    next();
    srst_n_i    = 1'b1;
    ast_ready_i = 1'b1;
    at_neg();
    chk("post vld", ast_valid_o, 0);
    chk("post rdy", ast_ready_o, 1);
    chk("post dat", ast_data_o, 0);
    chk("post ch", ast_channel_o, 0);
    next();
    at_neg();
    chk("post vld2", ast_valid_o, 0);
    next();
    one_word("after", d2, 1'b1, 1'b1, 4'd5, 10'd9, 2, 3'd5);

    // Random backpressure and input gaps over 10 packets
    for (int p = 0; p < 10; p++) begin
      nw = $urandom_range(1, 5);
      pkt_ch.push_back(channel_t'($urandom));
      for (int w = 0; w < nw; w++) begin
        wt.data  = {$urandom, $urandom, $urandom, $urandom};
        wt.sop   = (w == 0);
        wt.eop   = (w == nw - 1);
        wt.empty = empty_in_t'($urandom_range(0, 15));
        wt.ch    = pkt_ch[p];
        wt.dly   = $urandom_range(0, 10);
        words.push_back(wt);
        vb = wt.eop ? 16 - int'(wt.empty) : 16;
        for (int b = 0; b < vb; b++) tx_q.push_back(wt.data[b*8 +: 8]);
      end
    end
    wi = 0;
    dly = words[0].dly;
    presenting = 1'b0;
    stalled = 1'b0;
    exp_sop = 1'b1;
    rx_pkts = 0;
    for (int cyc = 0; cyc < 5000 && rx_pkts < 10; cyc++) begin
      ast_ready_i = 1'($urandom_range(0, 1));
      if (!presenting && wi < words.size()) begin
        if (dly == 0) presenting = 1'b1;
        else          dly--;
      end
      if (presenting) drive(1'b1, words[wi].data, words[wi].sop, words[wi].eop,
                            words[wi].empty, words[wi].ch);
      else            drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
      at_neg();
      cur = {48'd0, ast_valid_o, ast_startofpacket_o, ast_endofpacket_o,
             ast_empty_o, ast_channel_o, ast_data_o};
      if (stalled) chk($sformatf("stall c%0d", cyc), cur, saved);
      stalled = 1'b0;
      if (ast_valid_o) begin
        if (ast_ready_i) begin
          chk($sformatf("rnd sop c%0d", cyc), ast_startofpacket_o, exp_sop);
          chk($sformatf("rnd ch c%0d", cyc), ast_channel_o, pkt_ch[rx_pkts]);
          nbytes = ast_endofpacket_o ? 8 - int'(ast_empty_o) : 8;
          for (int b = 0; b < nbytes; b++) rx_q.push_back(ast_data_o[b*8 +: 8]);
          exp_sop = ast_endofpacket_o;
          if (ast_endofpacket_o) rx_pkts++;
        end else begin
          stalled = 1'b1;
          saved = cur;
        end
      end
      if (presenting && ast_ready_o) begin
        presenting = 1'b0;
        wi++;
        if (wi < words.size()) dly = words[wi].dly;
      end
      next();
    end
    chk("rnd pkts", rx_pkts, 10);
    chk("rnd len", rx_q.size(), tx_q.size());
    for (int i = 0; i < tx_q.size() && i < rx_q.size(); i++)
      chk($sformatf("rnd byte %0d", i), rx_q[i], tx_q[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
